// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the multicycle shifter: shift-mode and FSM state encodings.
package seq_shifter_pkg;

  // Shift modes as presented on the mode input
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROL = 2'b11
  } sh_mode_e;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-step shifter: shifts data by k (0..STEP) in the given mode
// and reports the last bit shifted out (for ROL, the last bit wrapped into bit 0).
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  sh_mode_e         mode,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  // One branch per legal step size; k=0 passes data through untouched.
  // out_bit is taken from a pre-shift by j-1 so every bit select is constant.
  always_comb begin
    logic [WIDTH-1:0] part;
    shifted = data;
    out_bit = 1'b0;
    part    = '0;
    for (int j = 1; j <= STEP; j++) begin
      if (k == KW'(j)) begin
        unique case (mode)
          SH_SLL: begin
            shifted = data << j;
            part    = data << (j - 1);
            out_bit = part[WIDTH-1];
          end
          SH_SRL: begin
            shifted = data >> j;
            part    = data >> (j - 1);
            out_bit = part[0];
          end
          SH_SRA: begin
            shifted = $unsigned($signed(data) >>> j);
            part    = data >> (j - 1);
            out_bit = part[0];
          end
          SH_ROL: begin
            shifted = (data << j) | (data >> (WIDTH - j));
            part    = data << (j - 1);
            out_bit = part[WIDTH-1];
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multicycle shifter: STEP bits per clock under a start/done handshake.
// Holds the control FSM, remaining-shift counter and result registers.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   y,
  output logic               carry
);

  localparam int KW = $clog2(STEP + 1);

  state_e             state_q, state_d;
  sh_mode_e           mode_q, mode_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               carry_q, carry_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   step_y;
  logic               step_bit;

  // Step size this cycle: min(STEP, rem). When STEP >= WIDTH, rem is always smaller.
  always_comb begin
    k = KW'(rem_q);
    if (STEP < WIDTH) begin
      if (rem_q >= SHAMT_W'(STEP)) k = KW'(STEP);
    end
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data    (y_q),
    .k       (k),
    .mode    (mode_q),
    .shifted (step_y),
    .out_bit (step_bit)
  );

  // Next-state logic: accept in IDLE/DONE, shift in SHIFT, single DONE cycle
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    y_d     = y_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          y_d     = a;
          mode_d  = sh_mode_e'(mode);
          rem_d   = shamt;
          carry_d = 1'b0;
          state_d = ST_SHIFT;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          y_d     = step_y;
          carry_d = step_bit;
          rem_d   = rem_q - SHAMT_W'(k);
          if (rem_d == '0) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= SH_SLL;
      y_q     <= '0;
      carry_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      rem_q   <= rem_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign y     = y_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: one STEP=1 and one STEP=4 instance share clock and reset.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start1, start4;
  logic [1:0]  mode1, mode4;
  logic [15:0] a1, a4;
  logic [3:0]  sh1, sh4;
  logic        ready1, busy1, done1, carry1;
  logic        ready4, busy4, done4, carry4;
  logic [15:0] y1, y4;

  typedef struct {
    logic [15:0] y;
    logic        c;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seq_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .shamt(sh1),
    .ready(ready1), .busy(busy1), .done(done1), .y(y1), .carry(carry1)
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .a(a4), .shamt(sh4),
    .ready(ready4), .busy(busy4), .done(done4), .y(y4), .carry(carry4)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected result whenever a DUT presents done
  task automatic mon(input int sel);
    exp_t        e;
    logic        d;
    logic [15:0] yy;
    logic        cc;
    d  = (sel == 1) ? done1 : done4;
    yy = (sel == 1) ? y1 : y4;
    cc = (sel == 1) ? carry1 : carry4;
    if (d === 1'b1) begin
      if ((sel == 1 && q1.size() == 0) || (sel == 4 && q4.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_done actual=done required=no_done", sel);
      end else begin
        e = (sel == 1) ? q1.pop_front() : q4.pop_front();
        $display("tx dut%0d y=%h carry=%b latency=%0d", sel, yy, cc, cyc - e.acc);
        chk($sformatf("dut%0d_y", sel), {16'h0, yy}, {16'h0, e.y});
        chk($sformatf("dut%0d_carry", sel), {31'h0, cc}, {31'h0, e.c});
        chk($sformatf("dut%0d_latency", sel), cyc - e.acc, e.lat);
      end
    end
  endtask

  initial forever begin @(negedge clk); mon(1); end
  initial forever begin @(negedge clk); mon(4); end

  // Issue one operation once the DUT is ready; push expectation at the accepting edge
  task automatic go(input int sel, input logic [1:0] m, input logic [15:0] av, input logic [3:0] s,
                    input logic [15:0] ey, input logic ec, input int el, input bit push);
    int   n;
    exp_t e;
    n = 0;
    while (((sel == 1) ? ready1 : ready4) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 1) ? ready1 : ready4) !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_ready_timeout actual=not_ready required=ready", sel);
      return;
    end
    if (sel == 1) begin start1 = 1'b1; mode1 = m; a1 = av; sh1 = s; end
    else          begin start4 = 1'b1; mode4 = m; a4 = av; sh4 = s; end
    @(posedge clk);
    #1;
    if (sel == 1) start1 = 1'b0; else start4 = 1'b0;
    if (push) begin
      e.y = ey; e.c = ec; e.lat = el; e.acc = cyc;
      if (sel == 1) q1.push_back(e); else q4.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q1.size() + q4.size(), 0);
  endtask

  initial begin
    int ndone;
    rst_n  = 1'b0;
    start1 = 1'b0; mode1 = 2'b00; a1 = 16'h0; sh1 = 4'h0;
    start4 = 1'b0; mode4 = 2'b00; a4 = 16'h0; sh4 = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_y1", {16'h0, y1}, 32'h0);
    chk("rst_carry1", {31'h0, carry1}, 32'h0);
    chk("rst_ready1", {31'h0, ready1}, 32'h1);
    chk("rst_busy1", {31'h0, busy1}, 32'h0);
    chk("rst_done1", {31'h0, done1}, 32'h0);
    chk("rst_y4", {16'h0, y4}, 32'h0);
    chk("rst_ready4", {31'h0, ready4}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // STEP=1 directed vectors
    go(1, 2'b00, 16'hffff, 4'd1, 16'hfffe, 1'b1, 1, 1'b1);
    go(1, 2'b01, 16'habcd, 4'd4, 16'h0abc, 1'b1, 4, 1'b1);
    go(1, 2'b10, 16'h8001, 4'd3, 16'hf000, 1'b0, 3, 1'b1);
    go(1, 2'b11, 16'habcd, 4'd8, 16'hcdab, 1'b1, 8, 1'b1);
    go(1, 2'b00, 16'h1234, 4'd0, 16'h1234, 1'b0, 1, 1'b1);
    go(1, 2'b10, 16'h4000, 4'd2, 16'h1000, 1'b0, 2, 1'b1);

    // STEP=4: single-cycle SRL, then back-to-back SLL accepted in the DONE cycle
    go(4, 2'b01, 16'habcd, 4'd4, 16'h0abc, 1'b1, 1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_in_done_cycle", {31'h0, done4}, 32'h1);
    go(4, 2'b00, 16'h0001, 4'd15, 16'h8000, 1'b0, 4, 1'b1);
    go(4, 2'b11, 16'h8001, 4'd5, 16'h0030, 1'b0, 2, 1'b1);

    // start pulsed while busy must be ignored
    go(1, 2'b01, 16'habcd, 4'd4, 16'h0abc, 1'b1, 4, 1'b1);
    chk("busy_during_shift", {31'h0, busy1}, 32'h1);
    chk("not_ready_during_shift", {31'h0, ready1}, 32'h0);
    @(negedge clk);
    start1 = 1'b1; mode1 = 2'b00; a1 = 16'hffff; sh1 = 4'd1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    drain();

    // Asynchronous reset mid-shift discards the operation
    go(1, 2'b11, 16'h1234, 4'd8, 16'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_y", {16'h0, y1}, 32'h0);
    chk("midrst_busy", {31'h0, busy1}, 32'h0);
    chk("midrst_ready", {31'h0, ready1}, 32'h1);
    chk("midrst_carry", {31'h0, carry1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done1 === 1'b1) ndone++;
    end
    chk("no_done_after_reset", ndone, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
